// File: rtl/p23_mem_port_arbiter_if.sv
// Valid/ready memory access channel with one outstanding access.
// The requester side is the master; the completer side is the slave.
interface p23_mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    valid;
  logic                    ready;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wmask;
  logic                    lock;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (
    output valid, addr, wdata, wmask, lock,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, wmask, lock,
    output ready, rdata
  );
endinterface

// File: rtl/p23_mem_port_arbiter.sv
// Two-requester arbiter for the single SoC memory port: registered grant FSM with
// round-robin or fixed priority, and a lock that holds the grant across beats.
module p23_mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  p23_mem_port_arbiter_if.slave  m0,
  p23_mem_port_arbiter_if.slave  m1,
  p23_mem_port_arbiter_if.master s,
  output logic [1:0]             grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state;
  logic   last;   // 0: m0 owned the port most recently, 1: m1

  logic                    mux_valid;
  logic [ADDR_WIDTH-1:0]   mux_addr;
  logic [DATA_WIDTH-1:0]   mux_wdata;
  logic [DATA_WIDTH/8-1:0] mux_wmask;
  logic                    mux_lock;
  logic                    m0_rdy;
  logic                    m1_rdy;
  logic [DATA_WIDTH-1:0]   m0_rd;
  logic [DATA_WIDTH-1:0]   m1_rd;

  logic pick_m0;
  assign pick_m0 = m0.valid && (!m1.valid || (ROUND_ROBIN == 0) || last);

  // The owner leaves its grant on completion or on withdrawing its request,
  // unless it holds lock; lock keeps the grant even with valid low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      last  <= 1'b1;
      grant <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (pick_m0) begin
            state <= GNT0;
            last  <= 1'b0;
            grant <= 2'b01;
          end else if (m1.valid) begin
            state <= GNT1;
            last  <= 1'b1;
            grant <= 2'b10;
          end
        end
        GNT0: begin
          if (!m0.lock && (!m0.valid || s.ready)) begin
            state <= IDLE;
            grant <= 2'b00;
          end
        end
        GNT1: begin
          if (!m1.lock && (!m1.valid || s.ready)) begin
            state <= IDLE;
            grant <= 2'b00;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Memory port and requester responses follow the registered owner only;
  // nothing passes through while IDLE, so s_ready there is ignored.
  always_comb begin
    mux_valid = 1'b0;
    mux_addr  = '0;
    mux_wdata = '0;
    mux_wmask = '0;
    mux_lock  = 1'b0;
    m0_rdy    = 1'b0;
    m1_rdy    = 1'b0;
    m0_rd     = '0;
    m1_rd     = '0;
    case (state)
      GNT0: begin
        mux_valid = m0.valid;
        mux_addr  = m0.addr;
        mux_wdata = m0.wdata;
        mux_wmask = m0.wmask;
        mux_lock  = m0.lock;
        m0_rdy    = s.ready & m0.valid;
        m0_rd     = s.rdata;
      end
      GNT1: begin
        mux_valid = m1.valid;
        mux_addr  = m1.addr;
        mux_wdata = m1.wdata;
        mux_wmask = m1.wmask;
        mux_lock  = m1.lock;
        m1_rdy    = s.ready & m1.valid;
        m1_rd     = s.rdata;
      end
      default: begin
      end
    endcase
  end

  assign s.valid  = mux_valid;
  assign s.addr   = mux_addr;
  assign s.wdata  = mux_wdata;
  assign s.wmask  = mux_wmask;
  assign s.lock   = mux_lock;
  assign m0.ready = m0_rdy;
  assign m0.rdata = m0_rd;
  assign m1.ready = m1_rdy;
  assign m1.rdata = m1_rd;

endmodule

// File: tb/tb_p23_mem_port_arbiter.sv
// Directed bench for p23_mem_port_arbiter: scoreboarded accesses on a round-robin
// instance plus a fixed-priority instance for contention ordering.
module tb_p23_mem_port_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  p23_mem_port_arbiter_if m0_if ();
  p23_mem_port_arbiter_if m1_if ();
  p23_mem_port_arbiter_if s_if ();
  logic [1:0] grant;

  p23_mem_port_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ROUND_ROBIN(1)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .grant (grant)
  );

  p23_mem_port_arbiter_if m0b_if ();
  p23_mem_port_arbiter_if m1b_if ();
  p23_mem_port_arbiter_if sb_if ();
  logic [1:0] grant_b;
  logic b0_valid = 1'b0;
  logic b1_valid = 1'b0;
  int   b0_cnt = 0;
  int   b1_cnt = 0;

  p23_mem_port_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ROUND_ROBIN(0)
  ) dut_fixed (
    .clk   (clk),
    .resetn(resetn),
    .m0    (m0b_if),
    .m1    (m1b_if),
    .s     (sb_if),
    .grant (grant_b)
  );

  assign m0b_if.valid = b0_valid;
  assign m0b_if.addr  = 32'h0000_0100;
  assign m0b_if.wdata = '0;
  assign m0b_if.wmask = '0;
  assign m0b_if.lock  = 1'b0;
  assign m1b_if.valid = b1_valid;
  assign m1b_if.addr  = 32'h0000_0200;
  assign m1b_if.wdata = '0;
  assign m1b_if.wmask = '0;
  assign m1b_if.lock  = 1'b0;
  assign sb_if.ready  = 1'b1;
  assign sb_if.rdata  = '0;

  always @(negedge clk) begin
    if (m0b_if.ready) b0_cnt++;
    if (m1b_if.ready) b1_cnt++;
  end

  // Memory model: read data is a fixed function of the address presented.
  logic resp_ready = 1'b0;
  logic force_ready = 1'b0;
  bit   resp_en = 1'b1;
  int   resp_cnt = 0;
  int   resp_lat = 1;

  assign s_if.rdata = s_if.addr ^ 32'hDEAD_0000;
  assign s_if.ready = resp_ready | force_ready;

  always @(posedge clk) begin
    if (!resetn || !resp_en) begin
      resp_ready <= 1'b0;
      resp_cnt   <= 0;
    end else if (resp_ready) begin
      resp_ready <= 1'b0;
      resp_cnt   <= 0;
    end else if (s_if.valid) begin
      if (resp_cnt + 1 >= resp_lat) resp_ready <= 1'b1;
      else resp_cnt <= resp_cnt + 1;
    end else begin
      resp_cnt <= 0;
    end
  end

  req_t exp0_q[$];
  req_t exp1_q[$];
  int   order_q[$];
  req_t mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every completion pops the oldest expected access of that requester.
  always @(negedge clk) begin
    if (resetn) begin
      if (m0_if.ready) begin
        check("m0 scoreboard entry", 64'(exp0_q.size() != 0), 1);
        if (exp0_q.size() != 0) begin
          mon_e = exp0_q.pop_front();
          check("m0 s_addr", 64'(s_if.addr), 64'(mon_e.addr));
          check("m0 s_wdata", 64'(s_if.wdata), 64'(mon_e.wdata));
          check("m0 s_wmask", 64'(s_if.wmask), 64'(mon_e.wmask));
          check("m0 rdata", 64'(m0_if.rdata), 64'(mon_e.addr ^ 32'hDEAD_0000));
          check("m0 grant", 64'(grant), 1);
          check("m1 ready during m0", 64'(m1_if.ready), 0);
          check("m1 rdata during m0", 64'(m1_if.rdata), 0);
          order_q.push_back(0);
        end
      end
      if (m1_if.ready) begin
        check("m1 scoreboard entry", 64'(exp1_q.size() != 0), 1);
        if (exp1_q.size() != 0) begin
          mon_e = exp1_q.pop_front();
          check("m1 s_addr", 64'(s_if.addr), 64'(mon_e.addr));
          check("m1 s_wdata", 64'(s_if.wdata), 64'(mon_e.wdata));
          check("m1 s_wmask", 64'(s_if.wmask), 64'(mon_e.wmask));
          check("m1 rdata", 64'(m1_if.rdata), 64'(mon_e.addr ^ 32'hDEAD_0000));
          check("m1 grant", 64'(grant), 2);
          check("m0 ready during m1", 64'(m0_if.ready), 0);
          check("m0 rdata during m1", 64'(m0_if.rdata), 0);
          order_q.push_back(1);
        end
      end
    end
  end

  task automatic push_exp(input int port, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m);
    req_t e;
    e.addr  = a;
    e.wdata = d;
    e.wmask = m;
    if (port == 0) exp0_q.push_back(e);
    else exp1_q.push_back(e);
  endtask

  task automatic issue(input int port, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic lk, input bit push);
    if (port == 0) begin
      m0_if.valid = 1'b1; m0_if.addr = a; m0_if.wdata = d; m0_if.wmask = m; m0_if.lock = lk;
    end else begin
      m1_if.valid = 1'b1; m1_if.addr = a; m1_if.wdata = d; m1_if.wmask = m; m1_if.lock = lk;
    end
    if (push) push_exp(port, a, d, m);
  endtask

  task automatic clear_masters();
    m0_if.valid = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.wmask = '0; m0_if.lock = 1'b0;
    m1_if.valid = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.wmask = '0; m1_if.lock = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    clear_masters();
    force_ready = 1'b0;
    resp_en = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  // Returns at the falling edge where the requester's ready is seen (or budget runs out).
  task automatic wait_done(input int port, input int budget, input string tag);
    logic got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      got = (port == 0) ? m0_if.ready : m1_if.ready;
    end
    check({tag, " completion"}, 64'(got), 1);
  endtask

  int  i0, i1, d0_cnt, d1_cnt;
  bit  dead, d0, d1, seen;

  initial begin
    clear_masters();

    // Single m0 read: one arbitration cycle, then the access.
    do_reset();
    @(negedge clk);
    check("reset grant", 64'(grant), 0);
    check("reset s_valid", 64'(s_if.valid), 0);
    check("reset s_addr", 64'(s_if.addr), 0);
    check("reset m0_ready", 64'(m0_if.ready), 0);
    check("reset m1_ready", 64'(m1_if.ready), 0);
    @(posedge clk); #1;
    issue(0, 32'h0000_1000, 32'h0, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    check("t1 arb s_valid", 64'(s_if.valid), 0);
    check("t1 arb grant", 64'(grant), 0);
    @(negedge clk);
    check("t1 s_valid", 64'(s_if.valid), 1);
    check("t1 s_addr", 64'(s_if.addr), 32'h0000_1000);
    check("t1 grant", 64'(grant), 1);
    check("t1 early m0_ready", 64'(m0_if.ready), 0);
    wait_done(0, 4, "t1");
    @(posedge clk); #1;
    m0_if.valid = 1'b0;
    @(negedge clk);
    check("t1 release grant", 64'(grant), 0);

    // Round-robin contention, four accesses each.
    do_reset();
    order_q.delete();
    @(posedge clk); #1;
    issue(0, 32'h0000_2000, 32'h0, 4'h0, 1'b0, 1'b1);
    issue(1, 32'h0000_3000, 32'h0, 4'h0, 1'b0, 1'b1);
    i0 = 1; i1 = 1; d0_cnt = 0; d1_cnt = 0; dead = 1'b0;
    for (int cyc = 0; cyc < 200 && (d0_cnt < 4 || d1_cnt < 4); cyc++) begin
      @(negedge clk);
      if (dead) begin
        check("rr dead cycle grant", 64'(grant), 0);
        dead = 1'b0;
      end
      d0 = m0_if.ready;
      d1 = m1_if.ready;
      @(posedge clk); #1;
      if (d0) begin
        d0_cnt++; dead = 1'b1;
        if (i0 < 4) begin issue(0, 32'h0000_2000 + 32'(4 * i0), 32'h0, 4'h0, 1'b0, 1'b1); i0++; end
        else m0_if.valid = 1'b0;
      end
      if (d1) begin
        d1_cnt++; dead = 1'b1;
        if (i1 < 4) begin issue(1, 32'h0000_3000 + 32'(4 * i1), 32'h0, 4'h0, 1'b0, 1'b1); i1++; end
        else m1_if.valid = 1'b0;
      end
    end
    check("rr m0 count", 64'(d0_cnt), 4);
    check("rr m1 count", 64'(d1_cnt), 4);
    check("rr order length", 64'(order_q.size()), 8);
    for (int k = 0; k < order_q.size() && k < 8; k++)
      check("rr order", 64'(order_q[k]), 64'(k % 2));

    // Locked three-beat m1 sequence with m0 waiting.
    do_reset();
    @(posedge clk); #1;
    issue(1, 32'h0000_5000, 32'h0, 4'h0, 1'b1, 1'b1);
    @(posedge clk); #1;
    issue(0, 32'h0000_4000, 32'h0, 4'h0, 1'b0, 1'b1);
    for (int b = 0; b < 3; b++) begin
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        check("lock grant", 64'(grant), 2);
        check("lock no gap", 64'(s_if.valid), 1);
        check("lock m0_ready", 64'(m0_if.ready), 0);
        seen = m1_if.ready;
      end
      check("lock beat completion", 64'(seen), 1);
      @(posedge clk); #1;
      if (b < 2) issue(1, 32'h0000_5000 + 32'(4 * (b + 1)), 32'h0, 4'h0, 1'b1, 1'b1);
      else m1_if.valid = 1'b0;
    end
    @(negedge clk);
    check("lock held idle grant", 64'(grant), 2);
    check("lock held s_valid", 64'(s_if.valid), 0);
    @(posedge clk); #1;
    m1_if.lock = 1'b0;
    @(negedge clk);
    check("lock drop grant", 64'(grant), 2);
    @(negedge clk);
    check("lock release idle", 64'(grant), 0);
    @(negedge clk);
    check("lock m0 granted", 64'(grant), 1);
    wait_done(0, 4, "lock m0");
    @(posedge clk); #1;
    m0_if.valid = 1'b0;

    // Granted m0 withdraws before completion; pending m1 follows.
    do_reset();
    resp_en = 1'b0;
    @(posedge clk); #1;
    issue(0, 32'h0000_6000, 32'h0, 4'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    m0_if.valid = 1'b0;
    force_ready = 1'b1;
    issue(1, 32'h0000_7000, 32'h0, 4'h0, 1'b0, 1'b1);
    @(negedge clk);
    check("drop grant held", 64'(grant), 1);
    check("drop s_valid", 64'(s_if.valid), 0);
    check("drop m0_ready", 64'(m0_if.ready), 0);
    @(negedge clk);
    check("drop idle grant", 64'(grant), 0);
    check("drop idle m0_ready", 64'(m0_if.ready), 0);
    check("drop idle m1_ready", 64'(m1_if.ready), 0);
    @(negedge clk);
    check("drop m1 grant", 64'(grant), 2);
    check("drop m1 ready", 64'(m1_if.ready), 1);
    @(posedge clk); #1;
    m1_if.valid = 1'b0;
    force_ready = 1'b0;
    resp_en = 1'b1;

    // s_ready asserted while IDLE, full-mask write.
    do_reset();
    resp_en = 1'b0;
    force_ready = 1'b1;
    @(negedge clk);
    check("idle ready m0", 64'(m0_if.ready), 0);
    check("idle ready m1", 64'(m1_if.ready), 0);
    check("idle s_wmask", 64'(s_if.wmask), 0);
    @(posedge clk); #1;
    issue(0, 32'h0000_8000, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    check("wr arb s_wmask", 64'(s_if.wmask), 0);
    check("wr arb m0_ready", 64'(m0_if.ready), 0);
    check("wr arb s_valid", 64'(s_if.valid), 0);
    @(negedge clk);
    check("wr s_wmask", 64'(s_if.wmask), 4'hF);
    check("wr s_wdata", 64'(s_if.wdata), 32'hCAFE_F00D);
    check("wr m0_ready", 64'(m0_if.ready), 1);
    @(posedge clk); #1;
    m0_if.valid = 1'b0;
    force_ready = 1'b0;
    resp_en = 1'b1;
    @(negedge clk);
    check("wr after s_wmask", 64'(s_if.wmask), 0);

    // Asynchronous reset in the middle of an m1 access.
    do_reset();
    resp_en = 1'b0;
    @(posedge clk); #1;
    issue(1, 32'h0000_9000, 32'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("areset arb grant", 64'(grant), 0);
    @(negedge clk);
    check("areset pre grant", 64'(grant), 2);
    check("areset pre s_valid", 64'(s_if.valid), 1);
    #2;
    resetn = 1'b0;
    force_ready = 1'b1;
    #1;
    check("areset s_valid", 64'(s_if.valid), 0);
    check("areset grant", 64'(grant), 0);
    check("areset m1_ready", 64'(m1_if.ready), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;
    force_ready = 1'b0;
    resp_en = 1'b1;
    push_exp(1, 32'h0000_9000, 32'h0, 4'h0);
    @(negedge clk);
    check("areset rearb grant", 64'(grant), 0);
    check("areset rearb s_valid", 64'(s_if.valid), 0);
    @(negedge clk);
    check("areset regrant", 64'(grant), 2);
    wait_done(1, 4, "areset m1");
    @(posedge clk); #1;
    m1_if.valid = 1'b0;

    // Fixed priority: m0 wins every contention until it withdraws.
    @(posedge clk); #1;
    b0_valid = 1'b1;
    b1_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("fixed no m1 grant", 64'(grant_b[1]), 0);
    end
    @(posedge clk); #1;
    check("fixed m0 beats", 64'(b0_cnt), 4);
    check("fixed m1 beats", 64'(b1_cnt), 0);
    b0_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      seen = (grant_b == 2'b10);
    end
    check("fixed m1 after m0 drops", 64'(seen), 1);
    @(posedge clk); #1;
    b1_valid = 1'b0;

    repeat (2) @(negedge clk);
    check("m0 scoreboard drained", 64'(exp0_q.size()), 0);
    check("m1 scoreboard drained", 64'(exp1_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
